mac_seq: RTL and testbench

Dot-product sequencer that sits directly upstream of the `mac` unit and feeds it. It accepts a job (`len` operand pairs plus a format bit) and clears the MAC. It then streams the pairs in over a valid/ready handshake into the MAC operand ports, with `acc` aligned to the MAC's internal operand register. After the last product accumulates, it captures the MAC's `out` into a result register and pulses `done`.

---
 rtl/mac_seq.sv | 126 ++++++++++++
 tb/tb_mac_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer feeding a downstream `mac` unit.
//
// A job (len operand pairs, fmt) is accepted in IDLE. The MAC is cleared for
// one cycle, the pairs are streamed into the MAC operand ports over a
// valid/ready handshake, and after a fixed 3-cycle drain the MAC output is
// captured into `result` with a one-cycle `done` pulse.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start, len, fmt   job request (sampled in IDLE only)
//   in_valid/in_ready operand-pair handshake; in_a, in_b operands
//   mac_a, mac_b      registered operands to MAC A/B
//   mac_acc           accumulate enable, aligned to the MAC operand register
//   mac_rst           active-high MAC clear (reset or CLEAR state)
//   mac_format        latched job format to the MAC
//   mac_out           MAC psum
//   busy, done        status; result holds the captured MAC output
module mac_seq #(
   parameter int bw      = 8,
   parameter int psum_bw = 16,
   parameter int len_w   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [len_w-1:0]   len,
   input  logic               fmt,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [bw-1:0]      in_a,
   input  logic [bw-1:0]      in_b,
   output logic [bw-1:0]      mac_a,
   output logic [bw-1:0]      mac_b,
   output logic               mac_acc,
   output logic               mac_rst,
   output logic               mac_format,
   input  logic [psum_bw-1:0] mac_out,
   output logic               busy,
   output logic               done,
   output logic [psum_bw-1:0] result
);

   typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

   state_t           state, state_nxt;
   logic [len_w-1:0] remaining;
   logic [1:0]       drain_cnt;
   logic [1:0]       acc_pipe;    // handshake delayed two edges -> mac_acc
   logic             fmt_q;
   logic             hs;
   logic             drain_last;

   // Handshake is decoded straight from state so the next-state logic does
   // not loop back through in_ready.
   assign hs         = in_valid && (state == STREAM) && (remaining != '0);
   assign drain_last = (state == DRAIN) && (drain_cnt == 2'd2);

   assign mac_acc    = acc_pipe[1];
   assign mac_format = fmt_q;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      mac_rst   = !reset;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = CLEAR;
         end
         CLEAR: begin
            mac_rst   = 1'b1;
            state_nxt = (remaining != '0) ? STREAM : DRAIN;
         end
         STREAM: begin
            in_ready = (remaining != '0);
            if (in_valid && (remaining == len_w'(1))) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == 2'd2) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         remaining <= '0;
         drain_cnt <= '0;
         acc_pipe  <= '0;
         fmt_q     <= 1'b0;
         mac_a     <= '0;
         mac_b     <= '0;
         result    <= '0;
         done      <= 1'b0;
      end else begin
         done     <= drain_last;
         acc_pipe <= {acc_pipe[0], hs};

         if ((state == IDLE) && start) begin
            remaining <= len;
            fmt_q     <= fmt;
         end

         // Operands hold through bubbles; only a handshake moves them.
         if (hs) begin
            mac_a     <= in_a;
            mac_b     <= in_b;
            remaining <= remaining - len_w'(1);
         end

         // Counter runs only inside DRAIN, so it is always 0 on entry.
         if ((state == DRAIN) && !drain_last) drain_cnt <= drain_cnt + 2'd1;
         else                                 drain_cnt <= '0;

         // By the exiting edge the last product has been in the psum for a cycle.
         if (drain_last) result <= mac_out;
      end
   end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: a timing model of the downstream MAC
// closes the loop, and expected results come from a plain dot-product model.
module tb_mac_seq;
   localparam int BW = 8, PW = 16, LW = 8;

   logic          clk = 1'b0, reset = 1'b0, start = 1'b0, fmt = 1'b0, in_valid = 1'b0;
   logic [LW-1:0] len = '0;
   logic [BW-1:0] in_a = '0, in_b = '0;
   logic          in_ready, mac_acc, mac_rst, mac_format, busy, done;
   logic [BW-1:0] mac_a, mac_b;
   logic [PW-1:0] mac_out, result;

   mac_seq #(.bw(BW), .psum_bw(PW), .len_w(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .fmt(fmt),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .mac_rst(mac_rst),
      .mac_format(mac_format), .mac_out(mac_out), .busy(busy), .done(done),
      .result(result)
   );

   always #5 clk = ~clk;

   int   n_tests = 0, n_fail = 0, cyc = 0;
   int   acc_hi = 0, done_hi = 0, rdy_hi = 0, fmt_err = 0, jobs_done = 0;
   logic cur_fmt = 1'b0;
   logic [7:0] qa[$], qb[$];
   int   gaps[$];

   function automatic int sval(input logic f, input logic [7:0] x);
      if (f) return x[7] ? -int'(x[6:0]) : int'(x[6:0]);
      return int'($signed(x));
   endfunction

   function automatic logic [15:0] enc(input logic f, input int s);
      int m;
      if (!f) return s[15:0];
      m = (s < 0) ? -s : s;
      return {(s < 0), m[14:0]};
   endfunction

   function automatic logic [15:0] ref_dot(input logic f, input int n);
      int s = 0;
      for (int i = 0; i < n; i++) s += sval(f, qa[i]) * sval(f, qb[i]);
      return enc(f, s);
   endfunction

   // MAC timing model: operands registered one edge, accumulated the next.
   int         psum = 0;
   logic [7:0] a_q = '0, b_q = '0;
   always @(posedge clk) begin
      if (mac_rst) begin
         psum <= 0; a_q <= '0; b_q <= '0;
      end else begin
         a_q <= mac_a; b_q <= mac_b;
         if (mac_acc) psum <= psum + sval(mac_format, a_q) * sval(mac_format, b_q);
      end
   end
   assign mac_out = enc(mac_format, psum);

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mac_acc)  acc_hi  <= acc_hi + 1;
      if (in_ready) rdy_hi  <= rdy_hi + 1;
      if (done)     done_hi <= done_hi + 1;
      if (busy && (mac_format !== cur_fmt)) fmt_err <= fmt_err + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left on a negedge. abort_after >= 0 resets mid-stream.
   task automatic run_job(input string tag, input logic f, input int n,
                          input int abort_after, input bit poke);
      int k, g, guard, L, S, acc0, rdy0, fe0, d0;
      bit seen;
      logic [15:0] exp;
      exp  = ref_dot(f, n);
      acc0 = acc_hi; rdy0 = rdy_hi; fe0 = fmt_err;
      cur_fmt = f;
      start = 1'b1; len = LW'(n); fmt = f;
      @(posedge clk); #1;
      start = 1'b0; fmt = ~f; len = LW'($urandom);
      @(negedge clk); S = cyc;
      chk({tag, "_clr_mac_rst"}, mac_rst, 1);
      chk({tag, "_clr_rdy"}, in_ready, 0);
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);   // must be ignored
      k = 0; g = 0; guard = 0; L = S;
      while (k < n && k != abort_after && guard < 300) begin
         @(negedge clk); guard++;
         start = poke && (guard == 2);
         len = LW'($urandom);
         if (g < gaps[k]) begin
            in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); g++;
         end else begin
            in_valid = 1'b1; in_a = qa[k]; in_b = qb[k];
            if (in_ready) begin L = cyc + 1; k++; g = 0; end
         end
      end
      if (abort_after >= 0) begin
         @(negedge clk);
         in_valid = 1'b0; start = 1'b0; reset = 1'b0;
         #1 chk({tag, "_rst_mac_rst"}, mac_rst, 1);
         @(negedge clk);
         chk({tag, "_rst_busy"}, busy, 0);
         chk({tag, "_rst_rdy"}, in_ready, 0);
         chk({tag, "_rst_acc"}, mac_acc, 0);
         chk({tag, "_rst_mac_a"}, mac_a, 0);
         chk({tag, "_rst_mac_rst2"}, mac_rst, 1);
         reset = 1'b1;
         d0 = done_hi;
         repeat (6) @(negedge clk);
         chk({tag, "_no_done"}, done_hi, d0);
         return;
      end
      chk({tag, "_accepts"}, k, n);
      seen = 0; guard = 0;
      while (!seen && guard < 12) begin
         @(negedge clk); guard++;
         in_valid = 1'b0; start = 1'b0;
         if (guard == 1 && n > 0) chk({tag, "_rdy_after_last"}, in_ready, 0);
         if (done) seen = 1;
      end
      chk({tag, "_done_seen"}, seen, 1);
      chk({tag, "_done_time"}, cyc, (n == 0) ? S + 4 : L + 3);
      chk({tag, "_result"}, result, exp);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_acc_cycles"}, acc_hi - acc0, n);
      chk({tag, "_fmt_const"}, fmt_err - fe0, 0);
      if (n == 0) chk({tag, "_rdy_never"}, rdy_hi - rdy0, 0);
      if (seen) jobs_done++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, ab;
      logic f;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_mac_b", mac_b, 0);
      chk("rst_mac_acc", mac_acc, 0);
      chk("rst_mac_format", mac_format, 0);
      chk("rst_mac_rst", mac_rst, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_mac_rst", mac_rst, 0);

      qa = '{8'd1, 8'd3, 8'hFF, 8'd2}; qb = '{8'd2, 8'd4, 8'd5, 8'hFD}; gaps = '{0, 0, 0, 0};
      run_job("tc", 1'b0, 4, -1, 0);
      chk("tc_lit", result, 16'h0003);

      qa = '{8'h83, 8'h02}; qb = '{8'h05, 8'h04}; gaps = '{0, 0};
      run_job("sm", 1'b1, 2, -1, 0);
      chk("sm_lit", result, 16'h8007);

      qa = '{8'd10, 8'hFE, 8'd1}; qb = '{8'd10, 8'd7, 8'd1}; gaps = '{0, 2, 1};
      run_job("bub", 1'b0, 3, -1, 1);
      chk("bub_lit", result, 16'h0057);

      qa.delete(); qb.delete(); gaps.delete();
      run_job("zero", 1'b0, 0, -1, 0);
      chk("zero_lit", result, 16'h0000);

      qa = '{8'd7, 8'd9, 8'd11, 8'd13}; qb = '{8'd5, 8'd5, 8'd5, 8'd5}; gaps = '{0, 0, 0, 0};
      run_job("abort", 1'b0, 4, 2, 0);
      qa = '{8'd1, 8'd1}; qb = '{8'd1, 8'd1}; gaps = '{0, 0};
      run_job("post", 1'b0, 2, -1, 0);
      chk("post_lit", result, 16'h0002);

      qa = '{8'd3}; qb = '{8'd3}; gaps = '{0};
      run_job("ja", 1'b0, 1, -1, 0);
      chk("ja_lit", result, 16'd9);
      qa = '{8'd2}; qb = '{8'd5}; gaps = '{0};
      run_job("jb", 1'b0, 1, -1, 0);
      chk("jb_lit", result, 16'd10);

      for (int j = 0; j < 25; j++) begin
         n = $urandom_range(0, 6);
         f = 1'($urandom_range(0, 1));
         qa.delete(); qb.delete(); gaps.delete();
         for (int i = 0; i < n; i++) begin
            if (f) begin
               qa.push_back({1'($urandom), 7'($urandom_range(0, 63))});
               qb.push_back({1'($urandom), 7'($urandom_range(0, 63))});
            end else begin
               qa.push_back(8'($urandom));
               qb.push_back(8'($urandom));
            end
            gaps.push_back(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
         end
         ab = (n >= 2 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
         run_job("rnd", f, n, ab, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("done_pulses", done_hi, jobs_done);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
